// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle multiply/divide sequencer.
// The block drives an external shared AND/OR/ADD/SUB ALU for one step per cycle.
// Multiply is unsigned shift-add. Divide is restoring division, with each trial
// subtract done on the ALU.
// Handshake toward execute: start / busy / done.
// Build option: define MULDIV_SIGNED_EN to add the signed_op input. With it,
// operands are converted to magnitudes at load, and a FIX state restores the
// result signs after the last step.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32  // iteration count; must equal WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
`ifdef MULDIV_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_binvert,
  output logic             alu_carryin,
  output logic [1:0]       alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryout
);

  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_FIN
  } state_t;

`ifdef MULDIV_SIGNED_EN
  localparam state_t S_AFTER_STEPS = S_FIX;
`else
  localparam state_t S_AFTER_STEPS = S_FIN;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, lo_q;  // HI/LO for multiply, R/Q for divide
  logic [WIDTH-1:0] m_q;         // multiplier M, or divisor D
  logic [CW-1:0]    cnt_q;
  logic             last_step;
  logic [WIDTH-1:0] s_div;
  logic             div_take;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign last_step = (cnt_q == CW'(STEPS - 1));
  // Divide: shift the next dividend bit into the partial remainder.
  // The bit shifted out of R is the msb, and it counts as part of the value.
  assign s_div     = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign div_take  = hi_q[WIDTH-1] | alu_carryout;
  assign busy      = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);

`ifdef MULDIV_SIGNED_EN
  logic             sa, sb;
  logic             neg_q;       // product or quotient sign
  logic             neg_rem_q;   // remainder sign
  logic             is_mul_q;
  logic [WIDTH-1:0] neg_hi_wide;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign sa    = signed_op & opa[WIDTH-1];
  assign sb    = signed_op & opb[WIDTH-1];
  assign mag_a = sa ? -opa : opa;
  assign mag_b = sb ? -opb : opb;
  // Upper half of -{hi,lo}: invert, and carry in only when the low half is zero.
  assign neg_hi_wide = ~hi_q + {{(WIDTH-1){1'b0}}, (lo_q == '0)};
  assign fix_lo = neg_q ? -lo_q : lo_q;
  assign fix_hi = is_mul_q ? (neg_q ? neg_hi_wide : hi_q)
                           : (neg_rem_q ? -hi_q : hi_q);
`else
  assign mag_a = opa;
  assign mag_b = opb;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    // This way, every flop samples values from before the edge.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default is assigned first, so every path drives state_d.
    // This prevents a latch from being inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op)             state_d = S_MUL;
          else if (opb == '0)  state_d = S_FIN;
          else                 state_d = S_DIV;
        end
      end
      S_MUL, S_DIV: if (last_step) state_d = S_AFTER_STEPS;
      S_FIX:   state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive: add in MUL, subtract in DIV, and idle (all zero) elsewhere.
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_binvert   = 1'b0;
    alu_carryin   = 1'b0;
    alu_operation = 2'b00;
    case (state_q)
      S_MUL: begin
        alu_a         = hi_q;
        alu_b         = m_q;
        alu_operation = 2'b01;
      end
      S_DIV: begin
        alu_a         = s_div;
        alu_b         = m_q;
        alu_binvert   = 1'b1;
        alu_carryin   = 1'b1;
        alu_operation = 2'b01;
      end
      default: ;
    endcase
  end

  // One iteration of shift-add or restoring divide, from the current ALU result.
  always_comb begin
    hi_step = hi_q;
    lo_step = lo_q;
    if (state_q == S_MUL) begin
      if (lo_q[0]) {hi_step, lo_step} = {alu_carryout, alu_result, lo_q[WIDTH-1:1]};
      else         {hi_step, lo_step} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
    end else if (state_q == S_DIV) begin
      hi_step = div_take ? alu_result : s_div;
      lo_step = {lo_q[WIDTH-2:0], div_take};
    end
  end

  // Datapath: operand load at accept, iteration, result capture and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data registers are reset along with control.
    // After reset, the outputs must read zero and no stale operand may remain.
    if (rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      result_hi   <= '0;
      result_lo   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      is_mul_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            hi_q        <= '0;
            lo_q        <= mag_a;
            m_q         <= mag_b;
            cnt_q       <= '0;
            div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_q       <= sa ^ sb;
            neg_rem_q   <= sa;
            is_mul_q    <= ~op;
`endif
            if (op && (opb == '0)) begin
              result_hi   <= opa;
              result_lo   <= '1;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          hi_q  <= hi_step;
          lo_q  <= lo_step;
          cnt_q <= last_step ? '0 : cnt_q + CW'(1);
`ifndef MULDIV_SIGNED_EN
          if (last_step) begin
            result_hi <= hi_step;
            result_lo <= lo_step;
            done      <= 1'b1;
          end
`endif
        end
`ifdef MULDIV_SIGNED_EN
        S_FIX: begin
          result_hi <= fix_hi;
          result_lo <= fix_lo;
          done      <= 1'b1;
        end
`endif
        S_FIN:   done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq.
// A behavioural ALU model closes the loop. Expected results come from plain
// SystemVerilog arithmetic. They are queued when an operation is issued, and
// compared when done is seen.
module tb_alu_muldiv_seq;
  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         rst, start, op;
`ifdef MULDIV_SIGNED_EN
  logic         signed_op;
`endif
  logic [W-1:0] opa, opb;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_hi, result_lo;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         alu_binvert, alu_carryin, alu_carryout;
  logic [1:0]   alu_operation;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bad_alu_op = 0;

  alu_muldiv_seq #(.WIDTH(W), .STEPS(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .op            (op),
`ifdef MULDIV_SIGNED_EN
    .signed_op     (signed_op),
`endif
    .opa           (opa),
    .opb           (opb),
    .busy          (busy),
    .done          (done),
    .result_hi     (result_hi),
    .result_lo     (result_lo),
    .div_by_zero   (div_by_zero),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_binvert   (alu_binvert),
    .alu_carryin   (alu_carryin),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_carryout  (alu_carryout)
  );

  always #5 clk = ~clk;

  // ALU model: operation 00 is AND, 01 is ADD with carry, 10 is OR.
  logic [W-1:0] b_eff;
  logic [W:0]   alu_sum;
  always_comb begin
    b_eff   = alu_binvert ? ~alu_b : alu_b;
    alu_sum = {1'b0, alu_a} + {1'b0, b_eff} + {{W{1'b0}}, alu_carryin};
    case (alu_operation)
      2'b00:   begin alu_result = alu_a & b_eff;    alu_carryout = 1'b0;       end
      2'b01:   begin alu_result = alu_sum[W-1:0];   alu_carryout = alu_sum[W]; end
      default: begin alu_result = alu_a | b_eff;    alu_carryout = 1'b0;       end
    endcase
  end

  always @(negedge clk) if (alu_operation[1]) bad_alu_op++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation. Optionally pulse start again at cycle inj while busy.
  // Then wait for done and compare the result against the scoreboard.
  task automatic do_op(input string tag, input logic o, input logic sg,
                       input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
    exp_t e, g;
    logic signed [63:0] xa, xb, p, q, r;
    int n, lat, busy_low;
    bit seen;
    xa = sg ? {{32{a[31]}}, a} : {32'b0, a};
    xb = sg ? {{32{b[31]}}, b} : {32'b0, b};
    if (!o) begin
      p = xa * xb;
      e.hi = p[63:32]; e.lo = p[31:0]; e.dbz = 1'b0;
    end else if (b == '0) begin
      e.hi = a; e.lo = '1; e.dbz = 1'b1;
    end else begin
      q = xa / xb;
      r = xa % xb;
      e.hi = r[31:0]; e.lo = q[31:0]; e.dbz = 1'b0;
    end
    lat = (o && b == '0) ? 1 : LAT;
    sb_q.push_back(e);

    @(negedge clk);
    op = o; opa = a; opb = b; start = 1'b1;
`ifdef MULDIV_SIGNED_EN
    signed_op = sg;
`endif
    n = 0; seen = 0; busy_low = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
      else if (!busy) busy_low++;
      if (n == 1) begin
        start = 1'b0;
        op = ~o; opa = $urandom; opb = $urandom;
      end
      if (inj != 0 && n == inj)     begin start = 1'b1; opa = 32'd999; opb = 32'd1000; end
      if (inj != 0 && n == inj + 1) start = 1'b0;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_busy_between"}, 64'(busy_low), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    g = sb_q.pop_front();
    check({tag, "_hi"}, 64'(result_hi), 64'(g.hi));
    check({tag, "_lo"}, 64'(result_lo), 64'(g.lo));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(g.dbz));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dcount;
    logic [W-1:0] ra, rb;
    rst = 1'b1; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
`ifdef MULDIV_SIGNED_EN
    signed_op = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(result_hi), 64'd0);
    check("reset_lo", 64'(result_lo), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    check("reset_alu_op", 64'(alu_operation), 64'd0);
    rst = 1'b0;

    do_op("mul_7x6", 1'b0, 1'b0, 32'd7, 32'd6, 0);
    do_op("mul_max", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op("div_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 0);
    do_op("div_msb", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h80000000, 0);
    do_op("div_5_0", 1'b1, 1'b0, 32'd5, 32'd0, 0);
    do_op("mul_3x3", 1'b0, 1'b0, 32'd3, 32'd3, 0);

    // A start pulse in the done cycle must be ignored, not queued.
    start = 1'b1; op = 1'b0; opa = 32'd2; opb = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("fin_start_ignored_a", 64'(busy), 64'd0);
    @(negedge clk);
    check("fin_start_ignored_b", 64'(busy), 64'd0);

    do_op("mul_inject", 1'b0, 1'b0, 32'd123456, 32'd789, 5);
    do_op("div_inject", 1'b1, 1'b0, 32'd1000000, 32'd37, 5);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      do_op("rand_mul", 1'b0, 1'b0, ra, rb, 0);
      rb = (i < 2) ? 32'($urandom_range(1, 65535)) : ($urandom | 32'h1);
      do_op("rand_div", 1'b1, 1'b0, ra, rb, 0);
    end

`ifdef MULDIV_SIGNED_EN
    do_op("smul_m7x6", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd6, 0);
    do_op("sdiv_m7_2", 1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, 0);
    do_op("sdiv_100_m7", 1'b1, 1'b1, 32'd100, 32'hFFFFFFF9, 0);
    do_op("sdiv_m9_0", 1'b1, 1'b1, 32'hFFFFFFF7, 32'd0, 0);
    for (int i = 0; i < 2; i++) begin
      ra = $urandom; rb = $urandom | 32'h1;
      do_op("rand_smul", 1'b0, 1'b1, ra, rb, 0);
      do_op("rand_sdiv", 1'b1, 1'b1, ra, rb, 0);
    end
`endif

    // Reset in the middle of a multiply must clear everything at once.
    // No done pulse may follow.
    @(negedge clk);
    op = 1'b0; opa = 32'h1234; opb = 32'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hi", 64'(result_hi), 64'd0);
    check("rst_mid_lo", 64'(result_lo), 64'd0);
    check("rst_mid_alu_a", 64'(alu_a), 64'd0);
    check("rst_mid_alu_op", 64'(alu_operation), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("rst_no_done", 64'(dcount), 64'd0);
    check("rst_idle", 64'(busy), 64'd0);

    do_op("mul_after_rst", 1'b0, 1'b0, 32'd11, 32'd13, 0);
    check("alu_op_legal", 64'(bad_alu_op), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that computes 32x32 multiply and 32/32 divide by driving the shared 32-bit AND/OR/ADD/SUB ALU one step per cycle.
- Multiply is unsigned shift-add; divide is restoring, using ALU subtract (Binvert=1, Carryin=1).
- The ALU is instantiated outside this block; the controller owns its inputs and reads Result/CarryOut.
- Sits between the instruction-execute stage and the ALU, with a start/busy/done handshake toward execute.

Parameters:
- WIDTH, 32, operand width; ALU width must match.
- STEPS, 32, iteration count; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0=multiply, 1=divide
- opa  input  32  multiplicand / dividend
- opb  input  32  multiplier / divisor
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle completion pulse
- result_hi  output  32  product[63:32] / remainder
- result_lo  output  32  product[31:0] / quotient
- div_by_zero  output  1  set on a divide with opb==0; valid with done
- alu_a  output  32  ALU operand a
- alu_b  output  32  ALU operand b
- alu_binvert  output  1  ALU Binvert
- alu_carryin  output  1  ALU Carryin
- alu_operation  output  2  ALU Operation; only 00 or 01 are ever driven
- alu_result  input  32  ALU Result
- alu_carryout  input  1  ALU CarryOut

Behaviour:
- Reset: all outputs 0, FSM=IDLE, step counter=0, internal registers 0. Reset asserted mid-operation aborts at once; no done pulse.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE & start & op=0: load HI=0, LO=opa, M=opb, cnt=0, go to MUL.
  - IDLE & start & op=1 & opb!=0: load R=0, Q=opa, D=opb, go to DIV.
  - IDLE & start & op=1 & opb==0: go to FIN directly; result_lo=32'hFFFFFFFF, result_hi=opa, div_by_zero=1.
- MUL step, one per cycle:
  - ALU drive: a=HI, b=M, Operation=01, Binvert=0, Carryin=0.
  - If LO[0]=1: {HI,LO} <= {CarryOut, Result, LO} >> 1.
  - If LO[0]=0: {HI,LO} <= {1'b0, HI, LO} >> 1.
- DIV step, one per cycle:
  - Form S={R[30:0],Q[31]} with msb=R[31].
  - ALU drive: a=S, b=D, Operation=01, Binvert=1, Carryin=1.
  - If msb|CarryOut: R<=Result and shift 1 into Q.
  - Otherwise: R<=S and shift 0 into Q.
- After STEPS steps (cnt wraps 31->0): go to FIN. In FIN, register the results and pulse done for one cycle, then return to IDLE.
- Latency: done is high in the 33rd cycle after the start-sample edge; divide-by-zero latency is 1. busy is high for the cycles in between.
- Outputs hold their values until the next accepted start. div_by_zero clears on the next accepted start.
- ALU drive in IDLE/FIN: a=0, b=0, Operation=00, Binvert=0, Carryin=0.
- start while busy or in FIN is ignored and not queued. start in the same cycle as done's return to IDLE is accepted.
- op, opa and opb are captured at accept; later changes have no effect.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), captured at accept.
  - When signed_op=1, operands are converted to magnitudes at load by local two's-complement logic, not the ALU.
  - An extra FIX state after the last step negates the results: product (64-bit) sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Latency becomes 34 for all signed and unsigned ops.
  - Divide-by-zero results are unchanged: lo=all ones, hi=raw opa.
- Undefined: no signed_op port, unsigned only, latency 33.

Test Plan:
- mul opa=7, opb=6 -> done exactly 33 cycles after start; hi=0, lo=42; busy high in between.
- mul opa=opb=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (exercises the CarryOut shift path).
- div 100/7 -> lo=14, hi=2. div 32'hFFFFFFFF/32'h80000000 -> lo=1, hi=32'h7FFFFFFF (exercises the msb path).
- div 5/0 -> done 1 cycle after start; lo=32'hFFFFFFFF, hi=5, div_by_zero=1. A following mul 3*3 clears div_by_zero and gives lo=9.
- Concurrency and reset:
  - start pulsed during MUL step 5 -> ignored; result is from the original operands.
  - rst during step 10 -> all outputs 0 immediately, IDLE, no done pulse.
- MULDIV_SIGNED_EN, signed_op=1:
  - (-7)*6 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFD6.
  - (-7)/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
  - Latency 34.
